// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: drives an external SubBytes/ShiftRows/MixColumns stage and applies AddRoundKey itself.
// Optional macro AES_SEQ_PERF_CNT_EN adds a last_latency output reporting accept-to-result cycles.
module aes_round_sequencer #(
  parameter int STATE_ARRAY_DIMENSION = 4,
  parameter int NUM_ROUNDS = 10,
  localparam int SW = 8 * STATE_ARRAY_DIMENSION * STATE_ARRAY_DIMENSION,
  localparam int RW = $clog2(NUM_ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid,
  input  logic [SW-1:0] state_array,
  output logic          ready,
  output logic [SW-1:0] state_array_out,
  output logic          valid_out,
  input  logic          next_is_ready,
  output logic [1:0]    stage_sel,
  output logic          stage_valid,
  output logic [SW-1:0] stage_state,
  input  logic          stage_ready,
  input  logic          stage_valid_out,
  input  logic [SW-1:0] stage_state_in,
  output logic          stage_next_is_ready,
  output logic [RW-1:0] rk_index,
  input  logic [SW-1:0] round_key,
  output logic [2:0]    dbg_state
`ifdef AES_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]   last_latency
`endif
);

  // Handshakes (upstream, downstream and stage): a transfer happens on a rising
  // edge where both valid and ready are 1; valid side holds its data until then.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDKEY0 = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_ADDKEY  = 3'd4,
    S_DONE    = 3'd5
  } fsm_state_e;

  typedef enum logic [1:0] {
    STEP_SUB   = 2'd0,
    STEP_SHIFT = 2'd1,
    STEP_MIX   = 2'd2
  } step_e;

  fsm_state_e    state_q, state_d;
  step_e         step_q, step_d;
  logic [RW-1:0] round_q, round_d;
  logic [SW-1:0] data_q, data_d;
  logic          last_round;

  assign last_round      = (round_q == RW'(NUM_ROUNDS));
  assign stage_state     = data_q;
  assign state_array_out = data_q;
  assign dbg_state       = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= STEP_SUB;
      round_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      round_q <= round_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    step_d              = step_q;
    round_d             = round_q;
    data_d              = data_q;
    ready               = 1'b0;
    valid_out           = 1'b0;
    stage_valid         = 1'b0;
    stage_next_is_ready = 1'b0;
    stage_sel           = 2'd0;
    rk_index            = '0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (valid) begin
          data_d  = state_array;
          round_d = '0;
          state_d = S_ADDKEY0;
        end
      end
      S_ADDKEY0: begin
        rk_index = '0;
        data_d   = data_q ^ round_key;
        round_d  = RW'(1);
        step_d   = STEP_SUB;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        stage_valid = 1'b1;
        stage_sel   = step_q;
        if (stage_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        stage_next_is_ready = 1'b1;
        if (stage_valid_out) begin
          data_d = stage_state_in;
          case (step_q)
            STEP_SUB: begin
              step_d  = STEP_SHIFT;
              state_d = S_ISSUE;
            end
            STEP_SHIFT: begin
              // The final round has no MixColumns.
              if (last_round) begin
                state_d = S_ADDKEY;
              end else begin
                step_d  = STEP_MIX;
                state_d = S_ISSUE;
              end
            end
            default: state_d = S_ADDKEY;
          endcase
        end
      end
      S_ADDKEY: begin
        rk_index = round_q;
        data_d   = data_q ^ round_key;
        if (last_round) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + RW'(1);
          step_d  = STEP_SUB;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        valid_out = 1'b1;
        if (next_is_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef AES_SEQ_PERF_CNT_EN
  // lat_cnt holds the index of the current cycle counted from the accept cycle,
  // so the value loaded when entering DONE is the cycle in which valid_out rises.
  logic [15:0] lat_cnt;
  logic [15:0] lat_inc;

  assign lat_inc = (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt      <= '0;
      last_latency <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        if (valid) lat_cnt <= 16'd1;
      end else begin
        lat_cnt <= lat_inc;
      end
      if (state_q != S_DONE && state_d == S_DONE) last_latency <= lat_inc;
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES stage/key-schedule models, directed plus randomized blocks.
module tb_aes_round_sequencer;
  localparam int SW = 128;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset, valid, ready, valid_out, next_is_ready;
  logic          stage_valid, stage_ready, stage_valid_out, stage_next_is_ready;
  logic [SW-1:0] state_array, state_array_out, stage_state, stage_state_in, round_key;
  logic [1:0]    stage_sel;
  logic [RW-1:0] rk_index;
  logic [2:0]    dbg_state;
`ifdef AES_SEQ_PERF_CNT_EN
  logic [15:0]   last_latency;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk_tab [11];
  logic [127:0] cur_key;

  int           stall_cycles = 0;
  int           stall_left   = 0;
  int           req_count    = 0;
  bit           in_req       = 1'b0;
  bit           res_pending  = 1'b0;
  logic [127:0] res_data     = '0;
  logic [127:0] held_state;
  logic [1:0]   held_sel;
  int           sel_log [$];
  int           rk_log [$];

  always #5 clk = ~clk;

  aes_round_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .valid               (valid),
    .state_array         (state_array),
    .ready               (ready),
    .state_array_out     (state_array_out),
    .valid_out           (valid_out),
    .next_is_ready       (next_is_ready),
    .stage_sel           (stage_sel),
    .stage_valid         (stage_valid),
    .stage_state         (stage_state),
    .stage_ready         (stage_ready),
    .stage_valid_out     (stage_valid_out),
    .stage_state_in      (stage_state_in),
    .stage_next_is_ready (stage_next_is_ready),
    .rk_index            (rk_index),
    .round_key           (round_key),
    .dbg_state           (dbg_state)
`ifdef AES_SEQ_PERF_CNT_EN
    ,
    .last_latency        (last_latency)
`endif
  );

  // Key schedule model: key for rk_index presented in the same cycle.
  assign round_key = (rk_index <= 4'd10) ? rk_tab[rk_index] : '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] calc_sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte (r,c) of a block sits at input byte index r+4c, first byte in the MSBs.
  function automatic logic [7:0] get_b(input logic [127:0] s, input int r, input int c);
    return s[127-8*(r+4*c) -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = get_b(s, r, (c + r) % 4);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = get_b(s, 0, c); a1 = get_b(s, 1, c); a2 = get_b(s, 2, c); a3 = get_b(s, 3, c);
      o[127-8*(4*c)   -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
      o[127-8*(4*c+3) -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
    end
    return o;
  endfunction

  function automatic logic [127:0] stage_op(input logic [1:0] sel, input logic [127:0] s);
    case (sel)
      2'd0:    return sub_bytes(s);
      2'd1:    return shift_rows(s);
      2'd2:    return mix_columns(s);
      default: return s;
    endcase
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] ^= rcon;
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r <= 10; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r < 10) s = mix_columns(s);
      s ^= rk_tab[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stage datapath responder: optional request stall, result one cycle after accept.
  initial begin
    stage_ready     = 1'b0;
    stage_valid_out = 1'b0;
    stage_state_in  = '0;
    forever begin
      @(negedge clk);
      if (in_req) check("stall_valid", 128'(stage_valid), 128'(1));
      if (reset || (!stage_valid && !stage_next_is_ready)) begin
        in_req      = 1'b0;
        res_pending = 1'b0;
      end
      stage_valid_out = res_pending;
      stage_state_in  = res_data;
      if (res_pending && stage_next_is_ready) res_pending = 1'b0;
      if (!ready && !stage_valid && !stage_next_is_ready && !valid_out)
        rk_log.push_back(int'(rk_index));
      stage_ready = 1'b0;
      if (stage_valid) begin
        if (!in_req) begin
          in_req     = 1'b1;
          stall_left = stall_cycles;
          held_sel   = stage_sel;
          held_state = stage_state;
        end else begin
          check("stall_sel", 128'(stage_sel), 128'(held_sel));
          check("stall_operand", stage_state, held_state);
        end
        if (stall_left == 0) begin
          stage_ready = 1'b1;
          res_data    = stage_op(stage_sel, stage_state);
          res_pending = 1'b1;
          in_req      = 1'b0;
          req_count++;
          sel_log.push_back(int'(stage_sel));
        end else begin
          stall_left--;
        end
      end
    end
  end

  task automatic start_block(input logic [127:0] pt, input bit keep_valid, input logic [127:0] next_pt);
    int n;
    sel_log.delete();
    rk_log.delete();
    req_count   = 0;
    valid       = 1'b1;
    state_array = pt;
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", 128'(ready), 128'(1));
    @(posedge clk); #1;
    valid       = keep_valid;
    state_array = next_pt;
  endtask

  task automatic wait_result(input logic [127:0] exp_ct, input int exp_lat);
    int lat;
    lat = 1;
    while (!valid_out && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 128'(lat), 128'(exp_lat));
    check("ciphertext", state_array_out, exp_ct);
    check("ready_low_in_done", 128'(ready), 128'(0));
`ifdef AES_SEQ_PERF_CNT_EN
    check("last_latency", 128'(last_latency), 128'(exp_lat));
`endif
  endtask

  task automatic finish_result(input logic [127:0] exp_ct, input int hold);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("held_valid_out", 128'(valid_out), 128'(1));
      check("held_data", state_array_out, exp_ct);
      check("held_ready", 128'(ready), 128'(0));
    end
    next_is_ready = 1'b1;
    @(posedge clk); #1;
    next_is_ready = 1'b0;
    check("valid_out_drop", 128'(valid_out), 128'(0));
    check("ready_after_done", 128'(ready), 128'(1));
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] exp_ct, input int hold,
                           input int exp_lat);
    start_block(pt, 1'b0, rand128());
    wait_result(exp_ct, exp_lat);
    finish_result(exp_ct, hold);
  endtask

  initial begin
    logic [127:0] fips_pt, fips_ct, pt, pt2, ct, ct2;
    int seq_exp [$];
    int n, st;
    reset         = 1'b1;
    valid         = 1'b0;
    next_is_ready = 1'b0;
    state_array   = '0;
    for (int i = 0; i < 256; i++) sbox_t[i] = calc_sbox(8'(i));
    fips_pt = 128'h3243f6a8885a308d313198a2e0370734;
    fips_ct = 128'h3925841d02dc09fbdc118597196a0b32;
    cur_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expand_key(cur_key);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(ready), 128'(1));
    check("rst_valid_out", 128'(valid_out), 128'(0));
    check("rst_stage_valid", 128'(stage_valid), 128'(0));
    check("rst_stage_next_is_ready", 128'(stage_next_is_ready), 128'(0));
    check("rst_stage_sel", 128'(stage_sel), 128'(0));
    check("rst_rk_index", 128'(rk_index), 128'(0));
    check("rst_state_out", state_array_out, 128'(0));
`ifdef AES_SEQ_PERF_CNT_EN
    check("rst_last_latency", 128'(last_latency), 128'(0));
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    // Known-answer block, zero-wait stages, with request and key-index order.
    stall_cycles = 0;
    run_block(fips_pt, fips_ct, 0, 70);
    for (int r = 1; r <= 10; r++) begin
      seq_exp.push_back(0);
      seq_exp.push_back(1);
      if (r < 10) seq_exp.push_back(2);
    end
    check("sel_count", 128'(sel_log.size()), 128'(29));
    for (int i = 0; i < 29 && i < sel_log.size(); i++)
      check($sformatf("sel_seq[%0d]", i), 128'(sel_log[i]), 128'(seq_exp[i]));
    check("rk_count", 128'(rk_log.size()), 128'(11));
    for (int i = 0; i < 11 && i < rk_log.size(); i++)
      check($sformatf("rk_seq[%0d]", i), 128'(rk_log[i]), 128'(i));

    // Stage backpressure: every request held off for three cycles.
    stall_cycles = 3;
    run_block(fips_pt, fips_ct, 0, 70 + 29 * 3);
    stall_cycles = 0;

    // Output backpressure at DONE.
    pt = rand128();
    run_block(pt, aes_encrypt(pt), 5, 70);

    // Random keys, plaintexts and stage stalls.
    for (int b = 0; b < 4; b++) begin
      cur_key = rand128();
      expand_key(cur_key);
      st = $urandom_range(0, 2);
      stall_cycles = st;
      pt = rand128();
      run_block(pt, aes_encrypt(pt), $urandom_range(0, 3), 70 + 29 * st);
    end
    stall_cycles = 0;

    // Reset while waiting for the round 4 ShiftRows result.
    start_block(rand128(), 1'b0, rand128());
    n = 0;
    while (!(stage_next_is_ready && req_count == 11) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_round4_wait", 128'(stage_next_is_ready && req_count == 11), 128'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ready", 128'(ready), 128'(1));
    check("abort_valid_out", 128'(valid_out), 128'(0));
    check("abort_stage_valid", 128'(stage_valid), 128'(0));
    check("abort_stage_next_is_ready", 128'(stage_next_is_ready), 128'(0));
    pt = rand128();
    run_block(pt, aes_encrypt(pt), 0, 70);

    // Two blocks with valid held high throughout.
    pt  = rand128();
    pt2 = rand128();
    ct  = aes_encrypt(pt);
    ct2 = aes_encrypt(pt2);
    start_block(pt, 1'b1, pt2);
    wait_result(ct, 70);
    finish_result(ct, 0);
    @(posedge clk); #1;
    valid = 1'b0;
    wait_result(ct2, 70);
    finish_result(ct2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (dbg_state %0d)", dbg_state);
    $fatal(1, "watchdog expired");
  end

endmodule
